// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory request protocol.
package cpu_types_pkg;

    // Status reported by the RAM model on every cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory-side arbiter states.
    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } arb_state_t;

    // Load value handed back when the RAM flags an access error.
    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/cmr_starve_ctr.sv
// Saturating count of data completions seen while an instruction fetch waits.
module cmr_starve_ctr #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic limit_reached
);

    logic [CNT_W-1:0] cnt;

    assign limit_reached = (cnt >= CNT_W'(LIMIT));

    // Clear has priority; increment holds once the limit is reached.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit_reached) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: arbitrates icache/dcache requests onto one RAM port.
module cache_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       WORD_W       = 32,
    parameter int unsigned       STARVE_LIMIT = 4,
    parameter logic [WORD_W-1:0] ERR_WORD     = WORD_W'(ERR_WORD_DEFAULT)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t state, next_state;
    ramstate_t  rs;
    logic       dreq;
    logic       ram_done;
    logic       i_done;
    logic       d_done;
    logic       limit_reached;

    assign rs       = ramstate_t'(ramstate);
    assign dreq     = dREN | dWEN;
    assign ram_done = (rs == ACCESS) || (rs == ERROR);

    cmr_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .CLK           (CLK),
        .nRST          (nRST),
        .inc           (d_done & iREN),
        .clr           (i_done | ~iREN),
        .limit_reached (limit_reached)
    );

    // Arbiter state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration, RAM port muxing and completion signalling.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        mem_err    = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && (!iREN || !limit_reached)) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait      = 1'b0;
                        i_done     = 1'b1;
                        next_state = IDLE;
                        if (rs == ERROR) begin
                            iload   = ERR_WORD;
                            mem_err = 1'b1;
                        end else begin
                            iload = ramload;
                        end
                    end
                end
            end
            DGRANT: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_done) begin
                        dwait      = 1'b0;
                        d_done     = 1'b1;
                        next_state = IDLE;
                        if (rs == ERROR) begin
                            mem_err = 1'b1;
                            if (!dWEN) dload = ERR_WORD;
                        end else if (!dWEN) begin
                            dload = ramload;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed scenarios then random traffic.
module tb_cache_mem_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam logic [31:0] ERRW  = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [1:0]  ramstate;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];

    cache_mem_responder #(
        .ADDR_W       (32),
        .WORD_W       (32),
        .STARVE_LIMIT (LIMIT),
        .ERR_WORD     (ERRW)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_iwait"}, iwait, 1);
        chk({tag, "_dwait"}, dwait, 1);
        chk({tag, "_iload"}, iload, 0);
        chk({tag, "_dload"}, dload, 0);
        chk({tag, "_ramREN"}, ramREN, 0);
        chk({tag, "_ramWEN"}, ramWEN, 0);
        chk({tag, "_ramaddr"}, ramaddr, 0);
        chk({tag, "_ramstore"}, ramstore, 0);
        chk({tag, "_mem_err"}, mem_err, 0);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    initial begin
        int          pulses[$];
        int          lat, streak, cur_streak, prev_streak, iw, maxiw, op;
        bit          en, cmpl, err, exp_d, cur_is_d;
        bit          prev_en, prev_cmpl, prev_ireq, prev_dreq, cur_ireq, cur_dreq;
        bit          i_done_p, d_done_p;
        logic [31:0] exp_val;

        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset values
        adv(); adv(); settle();
        chk_reset_outs("reset");
        adv(); nRST = 1'b1;

        // Instruction fetch with three BUSY cycles
        adv(); iREN = 1; iaddr = 32'h40; ramstate = FREE; settle();
        chk("if_c0_ramREN", ramREN, 0);
        chk("if_c0_iwait", iwait, 1);
        adv(); ramstate = BUSY; settle();
        chk("if_c1_ramREN", ramREN, 1);
        chk("if_c1_ramaddr", ramaddr, 32'h40);
        chk("if_c1_iwait", iwait, 1);
        for (int c = 2; c < 4; c++) begin
            adv(); settle();
            chk("if_busy_iwait", iwait, 1);
            chk("if_busy_dwait", dwait, 1);
        end
        adv(); ramstate = ACCESS; ramload = 32'h8C220004; settle();
        chk("if_c4_iwait", iwait, 0);
        chk("if_c4_iload", iload, 32'h8C220004);
        chk("if_c4_dwait", dwait, 1);
        chk("if_c4_mem_err", mem_err, 0);
        adv(); iREN = 0; ramstate = FREE; settle();
        chk("if_c5_iwait", iwait, 1);
        chk("if_c5_ramREN", ramREN, 0);

        // Simultaneous requests: data wins, one idle cycle, then instruction
        adv(); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
        ramstate = ACCESS; ramload = 32'h11112222; settle();
        chk("sim_c0_iwait", iwait, 1);
        chk("sim_c0_dwait", dwait, 1);
        adv(); settle();
        chk("sim_c1_dwait", dwait, 0);
        chk("sim_c1_dload", dload, 32'h11112222);
        chk("sim_c1_ramaddr", ramaddr, 32'h100);
        chk("sim_c1_iwait", iwait, 1);
        adv(); dREN = 0; settle();
        chk("sim_c2_iwait", iwait, 1);
        chk("sim_c2_dwait", dwait, 1);
        chk("sim_c2_ramREN", ramREN, 0);
        adv(); ramload = 32'h33334444; settle();
        chk("sim_c3_iwait", iwait, 0);
        chk("sim_c3_iload", iload, 32'h33334444);
        chk("sim_c3_ramaddr", ramaddr, 32'h44);
        adv(); iREN = 0; settle();
        chk("sim_c4_iwait", iwait, 1);

        // Starvation: iREN held, data requests continuous
        adv(); iREN = 1; dREN = 1; iaddr = 32'h48; daddr = 32'h104; ramstate = ACCESS;
        for (int n = 0; n < 24; n++) begin
            settle();
            if (!dwait) pulses.push_back(1);
            if (!iwait) pulses.push_back(2);
            adv();
        end
        chk("starve_npulses_ge10", pulses.size() >= 10, 1);
        for (int i = 0; i < 10; i++) begin
            chk("starve_seq", (i < pulses.size()) ? pulses[i] : 0, (i % 5 == 4) ? 2 : 1);
        end
        iREN = 0; dREN = 0; settle();

        // Write
        adv(); dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY;
        ramload = 32'hFFFFFFFF; settle();
        chk("wr_c0_dwait", dwait, 1);
        adv(); settle();
        chk("wr_c1_ramWEN", ramWEN, 1);
        chk("wr_c1_ramREN", ramREN, 0);
        chk("wr_c1_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_c1_ramaddr", ramaddr, 32'h200);
        chk("wr_c1_dwait", dwait, 1);
        adv(); ramstate = ACCESS; settle();
        chk("wr_c2_dwait", dwait, 0);
        chk("wr_c2_dload", dload, 0);
        chk("wr_c2_iwait", iwait, 1);
        chk("wr_c2_mem_err", mem_err, 0);
        adv(); dWEN = 0; ramstate = FREE; settle();
        chk("wr_c3_dwait", dwait, 1);
        chk("wr_c3_ramWEN", ramWEN, 0);

        // RAM error on an instruction fetch
        adv(); iREN = 1; iaddr = 32'h80; ramstate = ERROR; settle();
        chk("err_c0_iwait", iwait, 1);
        chk("err_c0_mem_err", mem_err, 0);
        adv(); settle();
        chk("err_c1_iwait", iwait, 0);
        chk("err_c1_iload", iload, 32'hBAD1BAD1);
        chk("err_c1_mem_err", mem_err, 1);
        adv(); iREN = 0; ramstate = FREE; settle();
        chk("err_c2_mem_err", mem_err, 0);
        chk("err_c2_iwait", iwait, 1);

        // Data read withdrawn during BUSY
        adv(); dREN = 1; daddr = 32'h300; ramstate = BUSY; settle();
        adv(); settle();
        chk("abort_c1_ramREN", ramREN, 1);
        chk("abort_c1_dwait", dwait, 1);
        adv(); dREN = 0; settle();
        chk("abort_c2_dwait", dwait, 1);
        adv(); dREN = 1; ramstate = ACCESS; settle();
        chk("abort_c3_dwait", dwait, 1);
        chk("abort_c3_ramREN", ramREN, 0);
        adv(); settle();
        chk("abort_c4_dwait", dwait, 0);
        adv(); dREN = 0; ramstate = FREE; settle();

        // Reset asserted mid-grant
        adv(); dREN = 1; daddr = 32'h400; ramstate = BUSY; settle();
        adv(); settle();
        chk("rst_c1_ramREN", ramREN, 1);
        adv(); nRST = 0; settle();
        chk("rst_c2_dwait", dwait, 1);
        adv(); ramstate = ACCESS; settle();
        chk_reset_outs("rst_c3");
        adv(); nRST = 1; settle();
        chk("rst_c4_dwait", dwait, 1);
        adv(); settle();
        chk("rst_c5_dwait", dwait, 0);
        chk("rst_c5_ramaddr", ramaddr, 32'h400);
        adv(); dREN = 0; ramstate = FREE; settle();
        adv(); settle();

        // Random traffic against a transaction-level model
        lat = -1; streak = 0; prev_streak = 0; iw = 0; maxiw = 0;
        prev_en = 0; prev_cmpl = 0; prev_ireq = 0; prev_dreq = 0;
        i_done_p = 0; d_done_p = 0; cur_is_d = 0;
        for (int n = 0; n < 3000; n++) begin
            adv();
            if (i_done_p || !iREN) begin
                iREN  = ($urandom_range(0, 2) != 0);
                iaddr = 32'($urandom_range(0, 7) * 4);
            end
            if (d_done_p || !(dREN || dWEN)) begin
                op     = $urandom_range(0, 3);
                dREN   = (op == 1) || (op == 3);
                dWEN   = (op >= 2);
                daddr  = 32'($urandom_range(0, 7) * 4);
                dstore = $urandom;
            end
            cur_ireq   = iREN;
            cur_dreq   = dREN || dWEN;
            cur_streak = streak;
            #1;
            en = ramREN || ramWEN;
            cmpl = 0; err = 0;
            if (en) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                if (lat > 0) begin
                    ramstate = BUSY; ramload = $urandom; lat--;
                end else begin
                    err      = ($urandom_range(0, 7) == 0);
                    ramstate = err ? ERROR : ACCESS;
                    ramload  = mem_rd(ramaddr);
                    cmpl     = 1; lat = -1;
                end
            end else begin
                lat = -1;
                ramstate = 2'($urandom_range(0, 3));
                ramload  = $urandom;
            end
            #1;
            chk("rnd_wait_excl", (!iwait && !dwait), 0);
            if (!prev_en) begin
                if (prev_ireq || prev_dreq) begin
                    exp_d = prev_dreq && (!prev_ireq || prev_streak < LIMIT);
                    cur_is_d = exp_d;
                    chk("rnd_grant_en", en, 1);
                    if (exp_d) begin
                        chk("rnd_dgrant_addr", ramaddr, daddr);
                        chk("rnd_dgrant_wen", ramWEN, dWEN);
                        chk("rnd_dgrant_ren", ramREN, !dWEN);
                    end else begin
                        chk("rnd_igrant_addr", ramaddr, iaddr);
                        chk("rnd_igrant_ren", ramREN, 1);
                        chk("rnd_igrant_wen", ramWEN, 0);
                    end
                end else begin
                    chk("rnd_idle_hold", en, 0);
                end
            end else if (prev_cmpl) begin
                chk("rnd_gap_after_done", en, 0);
            end else begin
                chk("rnd_grant_held", en, 1);
            end
            if (en && cmpl) begin
                chk("rnd_mem_err", mem_err, err);
                if (cur_is_d) begin
                    exp_val = dWEN ? 32'h0 : (err ? ERRW : mem_rd(daddr));
                    chk("rnd_d_dwait", dwait, 0);
                    chk("rnd_d_iwait", iwait, 1);
                    chk("rnd_d_dload", dload, exp_val);
                    if (dWEN) begin
                        chk("rnd_d_ramstore", ramstore, dstore);
                        if (!err) mem[daddr] = dstore;
                    end
                end else begin
                    exp_val = err ? ERRW : mem_rd(iaddr);
                    chk("rnd_i_iwait", iwait, 0);
                    chk("rnd_i_dwait", dwait, 1);
                    chk("rnd_i_iload", iload, exp_val);
                end
            end else begin
                chk("rnd_nc_iwait", iwait, 1);
                chk("rnd_nc_dwait", dwait, 1);
                chk("rnd_nc_mem_err", mem_err, 0);
            end
            i_done_p = en && cmpl && !cur_is_d;
            d_done_p = en && cmpl && cur_is_d;
            if (!cur_ireq || i_done_p) streak = 0;
            else if (d_done_p && streak < LIMIT) streak++;
            if (cur_ireq && !i_done_p) iw++;
            else iw = 0;
            if (iw > maxiw) maxiw = iw;
            prev_en     = en;
            prev_cmpl   = en && cmpl;
            prev_ireq   = cur_ireq;
            prev_dreq   = cur_dreq;
            prev_streak = cur_streak;
        end
        chk("rnd_ifetch_latency_bound", maxiw <= 80, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
